// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a programmable reset/flush value.
module dff_pipe #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           d,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v_reg;
    logic [DEPTH-1:0]            v_next;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0][WIDTH-1:0] stage_data;
    logic [CW-1:0]               count_reg;
    logic [CW-1:0]               count_next;
    logic                        accept;

    // A stage advances when it is valid and its successor is empty or itself advancing,
    // so the chain is resolved from the output end backwards.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v_reg[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v_reg[i] & (~v_reg[i+1] | adv[i+1]);
        end
    end

    assign in_ready = ~rst & ~flush & (~v_reg[0] | adv[0]);
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             load;
            logic [WIDTH-1:0] src;
            logic [WIDTH-1:0] data_reg;

            if (gi == 0) begin : g_head
                assign load = accept;
                assign src  = d;
            end else begin : g_body
                assign load = adv[gi-1];
                assign src  = stage_data[gi-1];
            end

            // Loading wins over draining: a stage that passes its item on while receiving
            // a new one stays valid.
            assign v_next[gi] = flush ? 1'b0 :
                                load  ? 1'b1 :
                                adv[gi] ? 1'b0 : v_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= RST_VAL;
                end else if (flush) begin
                    data_reg <= RST_VAL;
                end else if (load) begin
                    data_reg <= src;
                end
            end

            assign stage_data[gi] = data_reg;
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(v_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg     <= '0;
            count_reg <= '0;
        end else begin
            v_reg     <= v_next;
            count_reg <= count_next;
        end
    end

    assign q         = stage_data[DEPTH-1];
    assign q_bar     = ~stage_data[DEPTH-1];
    assign out_valid = v_reg[DEPTH-1];
    assign count     = count_reg;

endmodule
